hex_keypad_scanner: RTL and testbench

Scans a 4x4 matrix hex keypad on the FPGA board and turns debounced key presses into a shifted-in hex value for the SOC's general-purpose input port. It drives keypad columns and reads rows, the input-side counterpart of the multiplexed seven-segment display scanner. It runs on the low-speed board clock, and its `value` output feeds a `gpI` word.

---
 rtl/hex_keypad_scanner_if.sv | 40 ++++
 rtl/hex_keypad_scanner.sv | 186 ++++++++++++++++++
 tb/tb_hex_keypad_scanner.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_keypad_scanner_if.sv
// hex_keypad_scanner_if: keypad matrix pins, clear and digit outputs of the
// hex keypad scanner bundled as one port. The entry handshake signals exist
// only when KEYPAD_ENTER_EN is defined.
// The master side drives the rows, clear and acknowledge (board/SOC).
// The slave side is the scanner itself.
interface hex_keypad_scanner_if #(
   parameter int DIGITS = 4
);
   logic [3:0]          row;
   logic                clr;
   logic [3:0]          col;
   logic [4*DIGITS-1:0] value;
   logic [3:0]          key_code;
   logic                key_strobe;
`ifdef KEYPAD_ENTER_EN
   logic [4*DIGITS-1:0] entry;
   logic                entry_valid;
   logic                entry_ack;

   modport master (
      output row, clr, entry_ack,
      input  col, value, key_code, key_strobe, entry, entry_valid
   );

   modport slave (
      input  row, clr, entry_ack,
      output col, value, key_code, key_strobe, entry, entry_valid
   );
`else
   modport master (
      output row, clr,
      input  col, value, key_code, key_strobe
   );

   modport slave (
      input  row, clr,
      output col, value, key_code, key_strobe
   );
`endif
endinterface

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: drives one active-low column at a time, samples the
// synchronised rows once per column slot, debounces press and release and
// shifts each accepted key code into a DIGITS-wide hex value.
// Optional feature macro: KEYPAD_ENTER_EN (key F commits value into entry).
module hex_keypad_scanner #(
   parameter int SCAN_DIV = 20,
   parameter int DEBOUNCE = 3,
   parameter int DIGITS   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   hex_keypad_scanner_if.slave  kp
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam int VAL_W = 4 * DIGITS;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       row_meta_q, row_sync_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [VAL_W-1:0] value_q, value_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_strobe_q, key_strobe_d;
   logic             tick, hit, accept;
   logic [1:0]       hit_row;
   logic [3:0]       code;
   logic [3:0]       col_w;
`ifdef KEYPAD_ENTER_EN
   logic [VAL_W-1:0] entry_q, entry_d;
   logic             entry_valid_q, entry_valid_d;
`endif

   assign tick    = (div_q == DIV_LAST);
   assign cnt_inc = cnt_q + CNT_W'(1);
   // Column index stays frozen while debouncing, so it completes the code.
   assign code    = {row_idx_d, col_idx_q};

   // Active-low column drive: only the selected column is pulled low.
   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col_w[gi] = (col_idx_q != 2'(gi));
   end

   assign kp.col        = col_w;
   assign kp.value      = value_q;
   assign kp.key_code   = key_code_q;
   assign kp.key_strobe = key_strobe_q;
`ifdef KEYPAD_ENTER_EN
   assign kp.entry       = entry_q;
   assign kp.entry_valid = entry_valid_q;
`endif

   // Row hit detection: any low row is a hit, lowest row index wins.
   always_comb begin
      hit     = ~&row_sync_q;
      hit_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row_sync_q[i]) hit_row = 2'(i);
      end
   end

   // State register, row synchroniser, divider and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_SCAN;
         row_meta_q   <= 4'hF;
         row_sync_q   <= 4'hF;
         div_q        <= '0;
         col_idx_q    <= 2'd0;
         row_idx_q    <= 2'd0;
         cnt_q        <= '0;
         value_q      <= '0;
         key_code_q   <= 4'd0;
         key_strobe_q <= 1'b0;
`ifdef KEYPAD_ENTER_EN
         entry_q       <= '0;
         entry_valid_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         row_meta_q   <= kp.row;
         row_sync_q   <= row_meta_q;
         div_q        <= div_d;
         col_idx_q    <= col_idx_d;
         row_idx_q    <= row_idx_d;
         cnt_q        <= cnt_d;
         value_q      <= value_d;
         key_code_q   <= key_code_d;
         key_strobe_q <= key_strobe_d;
`ifdef KEYPAD_ENTER_EN
         entry_q       <= entry_d;
         entry_valid_q <= entry_valid_d;
`endif
      end
   end

   // Next-state logic: scan, debounce the press, one accept cycle, debounce release.
   always_comb begin
      state_d   = state_q;
      div_d     = tick ? '0 : div_q + DIV_W'(1);
      col_idx_d = col_idx_q;
      row_idx_d = row_idx_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_SCAN: begin
            if (tick) begin
               if (hit) begin
                  row_idx_d = hit_row;
                  cnt_d     = CNT_W'(1);
                  state_d   = (DEBOUNCE == 1) ? ST_PRESSED : ST_DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (tick) begin
               if (hit && (hit_row == row_idx_q)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) state_d = ST_PRESSED;
               end else begin
                  state_d = ST_SCAN;
               end
            end
         end
         ST_PRESSED: begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
         end
         ST_RELEASE: begin
            if (tick) begin
               if (!hit) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     state_d   = ST_SCAN;
                     col_idx_d = col_idx_q + 2'd1;
                     cnt_d     = '0;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   // Output logic: strobe, key code and value load on the edge entering PRESSED.
   always_comb begin
      accept       = (state_d == ST_PRESSED) && (state_q != ST_PRESSED);
      key_strobe_d = accept;
      key_code_d   = accept ? code : key_code_q;
      value_d      = value_q;
`ifdef KEYPAD_ENTER_EN
      entry_d       = entry_q;
      entry_valid_d = entry_valid_q && !kp.entry_ack;
      if (accept) begin
         if (code == 4'hF) begin
            // A pending entry makes a further enter press a no-op.
            if (!entry_valid_q) begin
               entry_d       = value_q;
               entry_valid_d = 1'b1;
               value_d       = '0;
            end
         end else begin
            value_d = {value_q[VAL_W-5:0], code};
         end
      end
`else
      if (accept) value_d = {value_q[VAL_W-5:0], code};
`endif
      // Clear wins over a same-cycle digit load.
      if (kp.clr) value_d = '0;
   end
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner: keypad matrix model plus a tick-level behavioural
// reference of the scanner, compared every cycle, with directed scenarios
// and randomized key presses, glitches and clears.
`timescale 1ns/1ps
module tb_hex_keypad_scanner;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 2;
   localparam int DIGITS   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] held = '0;
   logic [3:0]  row_pins;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          strobes = 0;
   bit          started = 1'b0;

   always #5 clk = ~clk;

   hex_keypad_scanner_if #(.DIGITS(DIGITS)) kp ();

   hex_keypad_scanner #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE(DEBOUNCE),
      .DIGITS  (DIGITS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kp (kp)
   );

   // Keypad matrix: a held key pulls its row low while its column is driven low.
   always_comb begin
      row_pins = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (held[4*r+c] && !kp.col[c]) row_pins[r] = 1'b0;
   end
   assign kp.row = row_pins;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   int          m_div, m_col, m_streak, m_cand, m_quiet;
   bit          m_hold, m_strobe;
   logic [3:0]  m_p1, m_p2, m_code;
   int unsigned m_value;
   int unsigned m_entry;
   bit          m_ev;

   always @(posedge clk) begin
      bit tick, fire, load;
      int r;
      if (!rst) begin
         m_div = 0; m_col = 0; m_streak = 0; m_cand = 0; m_quiet = 0;
         m_hold = 0; m_strobe = 0; m_p1 = 4'hF; m_p2 = 4'hF;
         m_code = 0; m_value = 0; m_entry = 0; m_ev = 0;
      end else begin
         tick  = (m_div == SCAN_DIV - 1);
         m_div = tick ? 0 : m_div + 1;
         r = -1;
         for (int i = 3; i >= 0; i--) if (!m_p2[i]) r = i;
         fire = 0;
         load = 0;
         if (m_strobe) begin
            m_hold  = 1;
            m_quiet = 0;
         end else if (tick) begin
            if (m_hold) begin
               if (r < 0) begin
                  m_quiet++;
                  if (m_quiet == DEBOUNCE) begin
                     m_hold = 0; m_quiet = 0; m_col = (m_col + 1) % 4;
                  end
               end else m_quiet = 0;
            end else if (m_streak == 0) begin
               if (r >= 0) begin m_cand = r; m_streak = 1; end
               else m_col = (m_col + 1) % 4;
            end else if (r == m_cand) m_streak++;
            else m_streak = 0;
            if (!m_hold && m_streak == DEBOUNCE) begin fire = 1; m_streak = 0; end
         end
         m_strobe = fire;
         if (fire) begin
            m_code = 4'(4 * m_cand + m_col);
`ifdef KEYPAD_ENTER_EN
            if (m_code == 4'hF) begin
               if (!m_ev) begin m_entry = m_value; m_ev = 1; load = 1; m_value = 0; end
            end else
`endif
            m_value = (m_value * 16 + m_code) % 65536;
         end
         if (kp.clr) m_value = 0;
`ifdef KEYPAD_ENTER_EN
         if (kp.entry_ack && !load) m_ev = 0;
`endif
         m_p2 = m_p1;
         m_p1 = kp.row;
      end
      started = 1'b1;
   end

   // Per-cycle comparison against the reference, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         check("col", 32'(kp.col), 32'(4'(~(4'b1 << m_col))));
         check("value", 32'(kp.value), m_value);
         check("key_code", 32'(kp.key_code), 32'(m_code));
         check("key_strobe", 32'(kp.key_strobe), 32'(m_strobe));
`ifdef KEYPAD_ENTER_EN
         check("entry", 32'(kp.entry), m_entry);
         check("entry_valid", 32'(kp.entry_valid), 32'(m_ev));
`endif
      end
      if (kp.key_strobe === 1'b1) strobes++;
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int k, input int hold, input int gap);
      held[k] = 1'b1;
      cyc(hold);
      held[k] = 1'b0;
      cyc(gap);
   endtask

   task automatic wait_strobe(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (kp.key_strobe === 1'b1) begin ok = 1; break; end
      end
      if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] scan_exp [5];
      int s0;
      scan_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      kp.clr = 1'b0;
`ifdef KEYPAD_ENTER_EN
      kp.entry_ack = 1'b0;
`endif
      // Reset and idle column rotation
      cyc(3);
      rst = 1'b1;
      check("reset_value", 32'(kp.value), 32'h0);
      check("reset_strobe", 32'(kp.key_strobe), 32'h0);
      check("reset_code", 32'(kp.key_code), 32'h0);
      check("scan_col0", 32'(kp.col), 32'(scan_exp[0]));
      for (int i = 1; i < 5; i++) begin
         cyc(4);
         check("scan_col", 32'(kp.col), 32'(scan_exp[i]));
      end

      // Single press row2/col1
      s0 = strobes;
      press(9, 40, 30);
      check("single_strobes", 32'(strobes - s0), 32'd1);
      check("single_code", 32'(kp.key_code), 32'd9);
      check("single_value", 32'(kp.value), 32'h0009);

      // Digits 1..5 with short glitches between them
      s0 = strobes;
      for (int k = 1; k <= 5; k++) begin
         press(k, 40, 15);
         held[$urandom_range(0, 15)] = 1'b1;
         cyc(3);
         held = '0;
         cyc(25);
      end
      check("digits_strobes", 32'(strobes - s0), 32'd5);
      check("digits_value", 32'(kp.value), 32'h2345);

      // Two rows on col0, clear during the accept cycle
      held[4]  = 1'b1;
      held[12] = 1'b1;
      wait_strobe("multi");
      check("multi_code", 32'(kp.key_code), 32'd4);
      check("multi_value_pre", 32'(kp.value), 32'h3454);
      kp.clr = 1'b1;
      cyc(1);
      kp.clr = 1'b0;
      check("multi_value_clr", 32'(kp.value), 32'h0);
      held = '0;
      cyc(30);

      // Reset during release with the key still held
      held[6] = 1'b1;
      wait_strobe("midrst");
      cyc(3);
      rst = 1'b0;
      cyc(2);
      check("midrst_col", 32'(kp.col), 32'b1110);
      check("midrst_value", 32'(kp.value), 32'h0);
      check("midrst_strobe", 32'(kp.key_strobe), 32'h0);
      rst = 1'b1;
      s0 = strobes;
      cyc(60);
      check("midrst_restrobe", 32'(strobes - s0), 32'd1);
      check("midrst_code", 32'(kp.key_code), 32'd6);
      held = '0;
      cyc(30);

`ifdef KEYPAD_ENTER_EN
      // Enter key commits, second enter dropped, ack clears
      kp.clr = 1'b1; cyc(1); kp.clr = 1'b0;
      press(10, 40, 30);
      press(11, 40, 30);
      press(15, 40, 30);
      check("enter_entry", 32'(kp.entry), 32'h00AB);
      check("enter_valid", 32'(kp.entry_valid), 32'd1);
      check("enter_value", 32'(kp.value), 32'h0);
      press(12, 40, 30);
      press(15, 40, 30);
      check("enter_drop_entry", 32'(kp.entry), 32'h00AB);
      check("enter_drop_value", 32'(kp.value), 32'h000C);
      kp.entry_ack = 1'b1; cyc(1); kp.entry_ack = 1'b0;
      check("enter_ack", 32'(kp.entry_valid), 32'd0);
`endif

      // Randomized presses, overlaps, glitches and clears
      for (int n = 0; n < 40; n++) begin
         held[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 4) == 0) held[$urandom_range(0, 15)] = 1'b1;
         cyc($urandom_range(1, 50));
         held = '0;
         if ($urandom_range(0, 3) == 0) begin
            kp.clr = 1'b1; cyc(1); kp.clr = 1'b0;
         end
`ifdef KEYPAD_ENTER_EN
         if ($urandom_range(0, 2) == 0) begin
            kp.entry_ack = 1'b1; cyc(1); kp.entry_ack = 1'b0;
         end
`endif
         cyc($urandom_range(1, 40));
      end
      cyc(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
